// File: rtl/reg_pkg.sv
// Shared definitions for the register-file building blocks.
// Optional feature macro used by the consumers of this package: NBIT_REGISTER_SAT_EN.
package reg_pkg;

    // Default register width, reused by the register file.
    localparam int unsigned REG_W = 8;

    // Function select encoding shared across the register file funsel bus.
    typedef enum logic [1:0] {
        FS_CLEAR = 2'b00,
        FS_LOAD  = 2'b01,
        FS_DEC   = 2'b10,
        FS_INC   = 2'b11
    } funsel_e;

endpackage

// File: rtl/nbit_register_next.sv
// Combinational next-state calculator for nbit_register.
// Optional feature: NBIT_REGISTER_SAT_EN makes INC/DEC saturate and drives clip.
// Ports:
//   q      - current register contents
//   i      - load data
//   funsel - operation select (reg_pkg::funsel_e encoding)
//   e      - enable; 0 = hold
//   next_q - value to be registered on the next edge
//   clip   - (NBIT_REGISTER_SAT_EN only) INC/DEC was saturated
module nbit_register_next
    import reg_pkg::*;
#(
    parameter int unsigned NBits = REG_W
) (
    input  logic [NBits-1:0] q,
    input  logic [NBits-1:0] i,
    input  logic [1:0]       funsel,
    input  logic             e,
`ifdef NBIT_REGISTER_SAT_EN
    output logic             clip,
`endif
    output logic [NBits-1:0] next_q
);

    // Operation decode; an unknown funsel falls to the default and holds q.
    always_comb begin
        next_q = q;
`ifdef NBIT_REGISTER_SAT_EN
        clip   = 1'b0;
`endif
        if (e) begin
            case (funsel)
                FS_CLEAR: next_q = '0;
                FS_LOAD:  next_q = i;
`ifdef NBIT_REGISTER_SAT_EN
                FS_DEC: begin
                    if (q == '0) clip = 1'b1;
                    else         next_q = q - NBits'(1);
                end
                FS_INC: begin
                    if (q == '1) clip = 1'b1;
                    else         next_q = q + NBits'(1);
                end
`else
                FS_DEC:   next_q = q - NBits'(1);
                FS_INC:   next_q = q + NBits'(1);
`endif
                default:  next_q = q;
            endcase
        end
    end

endmodule

// File: rtl/nbit_register.sv
// N-bit general-purpose register: clear / load / decrement / increment.
// Optional feature: NBIT_REGISTER_SAT_EN (saturating INC/DEC plus sat output).
// Ports:
//   clk    - clock, rising edge active
//   rst    - asynchronous active-high reset, loads RESET_VAL
//   e      - enable; 0 = hold
//   funsel - operation select (reg_pkg::funsel_e encoding)
//   i      - load data
//   q      - registered contents
//   sat    - (NBIT_REGISTER_SAT_EN only) previous INC/DEC was clipped
module nbit_register
    import reg_pkg::*;
#(
    parameter int unsigned     NBits     = REG_W,
    parameter logic [NBits-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             e,
    input  logic [1:0]       funsel,
    input  logic [NBits-1:0] i,
`ifdef NBIT_REGISTER_SAT_EN
    output logic             sat,
`endif
    output logic [NBits-1:0] q
);

    logic [NBits-1:0] next_q;
`ifdef NBIT_REGISTER_SAT_EN
    logic             clip;
`endif

    nbit_register_next #(
        .NBits (NBits)
    ) u_next (
        .q      (q),
        .i      (i),
        .funsel (funsel),
        .e      (e),
`ifdef NBIT_REGISTER_SAT_EN
        .clip   (clip),
`endif
        .next_q (next_q)
    );

    // State flops; reset takes effect immediately and overrides any operation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q   <= RESET_VAL;
`ifdef NBIT_REGISTER_SAT_EN
            sat <= 1'b0;
`endif
        end else begin
            q   <= next_q;
`ifdef NBIT_REGISTER_SAT_EN
            sat <= clip;
`endif
        end
    end

endmodule

// File: tb/tb_nbit_register.sv
// Scoreboard bench for nbit_register: an 8-bit instance (RESET_VAL=0) and a
// 4-bit instance (RESET_VAL=0xA). Expectations are queued by the driver and
// drained by an independent monitor. Honors NBIT_REGISTER_SAT_EN.
module tb_nbit_register;
    import reg_pkg::*;

`ifdef NBIT_REGISTER_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       e8, e4;
    logic [1:0] funsel;
    logic [7:0] i;
    logic [7:0] q8;
    logic [3:0] q4;
`ifdef NBIT_REGISTER_SAT_EN
    logic       sat8, sat4;
`endif

    int vectors     = 0;
    int miscompares = 0;

    // Scoreboard: parallel queues of name / target DUT / expected q / expected sat.
    string      sb_name[$];
    int         sb_dut[$];
    logic [7:0] sb_q[$];
    logic       sb_sat[$];
    event       mon_ev;

    always #5 clk = ~clk;

    nbit_register #(.NBits(8), .RESET_VAL(8'h00)) dut8 (
        .clk    (clk),
        .rst    (rst),
        .e      (e8),
        .funsel (funsel),
        .i      (i),
`ifdef NBIT_REGISTER_SAT_EN
        .sat    (sat8),
`endif
        .q      (q8)
    );

    nbit_register #(.NBits(4), .RESET_VAL(4'hA)) dut4 (
        .clk    (clk),
        .rst    (rst),
        .e      (e4),
        .funsel (funsel),
        .i      (i[3:0]),
`ifdef NBIT_REGISTER_SAT_EN
        .sat    (sat4),
`endif
        .q      (q4)
    );

    // Apply one command for one clock edge; returns just after the edge.
    task automatic drive(input logic en8, input logic en4, input logic [1:0] fs,
                         input logic [7:0] d);
        @(negedge clk);
        e8     = en8;
        e4     = en4;
        funsel = fs;
        i      = d;
        @(posedge clk);
        #1;
    endtask

    // Queue an expectation and wake the monitor.
    task automatic chk(input string nm, input int dut, input logic [7:0] exq,
                       input logic exs);
        sb_name.push_back(nm);
        sb_dut.push_back(dut);
        sb_q.push_back(exq);
        sb_sat.push_back(exs);
        ->mon_ev;
        #1;
    endtask

    // Monitor: drain every queued expectation against the live outputs.
    initial begin
        string      nm;
        int         d;
        logic [7:0] exq;
        logic       exs;
        logic [7:0] act;
        forever begin
            @(mon_ev);
            while (sb_name.size() != 0) begin
                nm  = sb_name.pop_front();
                d   = sb_dut.pop_front();
                exq = sb_q.pop_front();
                exs = sb_sat.pop_front();
                act = (d == 0) ? q8 : {4'h0, q4};
                vectors++;
                if (act !== exq) begin
                    miscompares++;
                    $display("FAIL %s: q=%h expected %h", nm, act, exq);
                end
`ifdef NBIT_REGISTER_SAT_EN
                vectors++;
                if (((d == 0) ? sat8 : sat4) !== exs) begin
                    miscompares++;
                    $display("FAIL %s_sat: sat=%b expected %b", nm,
                             (d == 0) ? sat8 : sat4, exs);
                end
`endif
            end
        end
    end

    initial begin
        rst = 1'b1; e8 = 1'b0; e4 = 1'b0; funsel = FS_CLEAR; i = 8'h00;
        #2;
        chk("reset_q8", 0, 8'h00, 1'b0);
        chk("reset_q4", 1, 8'h0A, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        // Async reset with no clock edge, then reset overriding a load.
        drive(1'b1, 1'b0, FS_LOAD, 8'h5A);
        chk("load_5a", 0, 8'h5A, 1'b0);
        #1 rst = 1'b1;
        #1;
        chk("async_rst", 0, 8'h00, 1'b0);
        drive(1'b1, 1'b0, FS_LOAD, 8'hAA);
        chk("rst_over_load", 0, 8'h00, 1'b0);
        #1 rst = 1'b0;

        // First edge after release is a normal edge; then hold.
        drive(1'b1, 1'b0, FS_LOAD, 8'hC3);
        chk("load_c3", 0, 8'hC3, 1'b0);
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 1'b0, FS_CLEAR, 8'hFF);
            chk("hold_c3", 0, 8'hC3, 1'b0);
        end
        chk("q4_hold_a", 1, 8'h0A, 1'b0);

        // Increment across the top.
        drive(1'b1, 1'b0, FS_LOAD, 8'hFE);
        drive(1'b1, 1'b0, FS_INC, 8'h00);
        chk("inc_fe", 0, 8'hFF, 1'b0);
        drive(1'b1, 1'b0, FS_INC, 8'h00);
        chk("inc_ff", 0, SAT ? 8'hFF : 8'h00, SAT);

        // Decrement across the bottom.
        drive(1'b1, 1'b0, FS_LOAD, 8'h01);
        chk("load_01", 0, 8'h01, 1'b0);
        drive(1'b1, 1'b0, FS_DEC, 8'h00);
        chk("dec_01", 0, 8'h00, 1'b0);
        drive(1'b1, 1'b0, FS_DEC, 8'h00);
        chk("dec_00", 0, SAT ? 8'h00 : 8'hFF, SAT);

        // Clear, gated and enabled.
        drive(1'b1, 1'b0, FS_LOAD, 8'h77);
        drive(1'b0, 1'b0, FS_CLEAR, 8'h00);
        chk("clear_gated", 0, 8'h77, 1'b0);
        drive(1'b1, 1'b0, FS_CLEAR, 8'h00);
        chk("clear", 0, 8'h00, 1'b0);

        // Mid-range increment/decrement.
        drive(1'b1, 1'b0, FS_LOAD, 8'h3C);
        drive(1'b1, 1'b0, FS_INC, 8'h00);
        chk("inc_3c", 0, 8'h3D, 1'b0);
        drive(1'b1, 1'b0, FS_DEC, 8'h00);
        chk("dec_3d", 0, 8'h3C, 1'b0);

        // 4-bit instance: load all-ones, increment.
        drive(1'b0, 1'b1, FS_LOAD, 8'hFF);
        chk("q4_load_f", 1, 8'h0F, 1'b0);
        drive(1'b0, 1'b1, FS_INC, 8'h00);
        chk("q4_inc_f", 1, SAT ? 8'h0F : 8'h00, SAT);
        chk("q8_held", 0, 8'h3C, 1'b0);

        // Reset returns the 4-bit instance to its RESET_VAL.
        #1 rst = 1'b1;
        #1;
        chk("q4_reset_a", 1, 8'h0A, 1'b0);
        #1 rst = 1'b0;

        // Bounded drain of anything left in the scoreboard.
        for (int k = 0; k < 10 && sb_name.size() != 0; k++) @(posedge clk);
        if (sb_name.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d entries left expected 0", sb_name.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
